// File: rtl/power_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : power_seq_pkg
//  Purpose  : Shared types and constants for the board power sequencer:
//             FSM state encoding, stage indices, fault code, rail vector
//             type and the stage-to-rail decode used by the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package power_seq_pkg;

    // Width of the shared settle / power-good timeout counter.
    localparam int c_timer_w = 32;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_UP_STEP    = 3'd1,
        ST_UP_WAIT_PG = 3'd2,
        ST_ON         = 3'd3,
        ST_DOWN_STEP  = 3'd4
    } seq_state_t;

    // Stage indices: the stage register holds how many steps of the
    // power-on sequence are currently applied.
    localparam logic [3:0] c_stage_off         = 4'd0;
    localparam logic [3:0] c_stage_atx         = 4'd1;
    localparam logic [3:0] c_stage_main        = 4'd2;
    localparam logic [3:0] c_stage_2v5         = 4'd3;
    localparam logic [3:0] c_stage_1v8         = 4'd4;
    localparam logic [3:0] c_stage_1v5_1v2     = 4'd5;
    localparam logic [3:0] c_stage_1v0         = 4'd6;
    localparam logic [3:0] c_stage_mgt_avcc    = 4'd7;
    localparam logic [3:0] c_stage_mgt_avttx   = 4'd8;
    localparam logic [3:0] c_stage_mgt_avccpll = 4'd9;
    localparam logic [3:0] c_stage_last        = c_stage_mgt_avccpll;

    // fault_stage code for a power-good lost while fully on.
    localparam logic [3:0] c_fault_stage_pg_loss = 4'hF;

    typedef struct packed {
        logic atx_ps_on_n;
        logic main_en;          // G12V / G5V / G3V3 enables
        logic inhibit_2v5;
        logic track_2v5;
        logic inhibit_1v8;
        logic inhibit_1v5_1v2;
        logic inhibit_1v0;
        logic mgt_avcc_en;
        logic mgt_avttx_en;
        logic mgt_avccpll_en;
    } rail_vec_t;

    // Every rail is a pure "stage >= k" decode, so rails can only switch in
    // sequence order regardless of how the stage register moves.
    function automatic rail_vec_t rails_for_stage(input logic [3:0] stage);
        rail_vec_t r;
        r.atx_ps_on_n     = !(stage >= c_stage_atx);
        r.main_en         =  (stage >= c_stage_main);
        r.inhibit_2v5     = !(stage >= c_stage_2v5);
        r.track_2v5       =  (stage >= c_stage_2v5);
        r.inhibit_1v8     = !(stage >= c_stage_1v8);
        r.inhibit_1v5_1v2 = !(stage >= c_stage_1v5_1v2);
        r.inhibit_1v0     = !(stage >= c_stage_1v0);
        r.mgt_avcc_en     =  (stage >= c_stage_mgt_avcc);
        r.mgt_avttx_en    =  (stage >= c_stage_mgt_avttx);
        r.mgt_avccpll_en  =  (stage >= c_stage_mgt_avccpll);
        return r;
    endfunction

    // Stages whose entry must be confirmed by a power-good input.
    function automatic logic stage_needs_pg(input logic [3:0] stage);
        return (stage == c_stage_atx) || (stage >= c_stage_mgt_avcc);
    endfunction

endpackage : power_seq_pkg
`default_nettype wire

// File: rtl/power_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : power_seq_timer
//  Purpose  : Loadable down-counter shared by settle-time and power-good
//             timeout measurement. Loading N makes o_expired rise N cycles
//             later (N = 0 -> expired on the very next cycle).
//  Ports    : clk, rst (async, active-high)
//             i_load        load strobe
//             i_load_value  value loaded on i_load
//             o_expired     counter has reached zero
//  Revision : 1.0  initial release
// ============================================================================
module power_seq_timer
    import power_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [c_timer_w-1:0] i_load_value,
    output logic                 o_expired
);

    logic [c_timer_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule : power_seq_timer
`default_nettype wire

// File: rtl/power_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : power_sequencer
//  Purpose  : Sequences the board supplies on and off in a fixed order.
//             A 0..9 stage register drives all rail outputs through a
//             registered "stage >= k" decode. Power-up waits on power-good
//             feedback for stages 1,7,8,9 and settles STEP_WAIT cycles after
//             every stage; power-down walks the stages back one every
//             STEP_WAIT+1 cycles. Power-good timeouts and losses raise a
//             fault and start an orderly power-down.
//  Ports    : clk, reset (async, active-high)
//             power_up / power_down        one-cycle requests
//             ATX_PWR_OK, MGT_*_PG         power-good feedback
//             power_up_done/power_down_done/power_fault  one-cycle strobes
//             fault_stage                  stage of the last fault (F = loss)
//             ATX_PS_ON_N, TRACK/INHIBIT_*, *_EN  rail controls
//  Revision : 1.0  initial release
// ============================================================================
module power_sequencer
    import power_seq_pkg::*;
#(
    parameter logic [31:0] STEP_WAIT  = 32'h0001_ffff,
    parameter logic [31:0] PG_TIMEOUT = 32'h003f_ffff
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_up,
    input  logic       power_down,
    input  logic       ATX_PWR_OK,
    input  logic       MGT_AVCC_PG,
    input  logic       MGT_AVTTX_PG,
    input  logic       MGT_AVCCPLL_PG,
    output logic       power_up_done,
    output logic       power_down_done,
    output logic       power_fault,
    output logic [3:0] fault_stage,
    output logic       ATX_PS_ON_N,
    output logic       TRACK_2V5,
    output logic       INHIBIT_2V5,
    output logic       INHIBIT_1V8,
    output logic       INHIBIT_1V5,
    output logic       INHIBIT_1V2,
    output logic       INHIBIT_1V0,
    output logic       MGT_AVCC_EN,
    output logic       MGT_AVTTX_EN,
    output logic       MGT_AVCCPLL_EN,
    output logic       G12V_EN,
    output logic       G5V_EN,
    output logic       G3V3_EN
);

    // The timer expires one cycle after reaching zero is observed, so a
    // PG wait loaded with PG_TIMEOUT-1 samples the power-good on exactly
    // PG_TIMEOUT cycles before declaring a fault.
    localparam logic [31:0] c_pg_wait_load =
        (PG_TIMEOUT == 32'd0) ? 32'd0 : (PG_TIMEOUT - 32'd1);

    seq_state_t r_state;
    seq_state_t w_state_next;
    logic [3:0] r_stage;
    logic [3:0] w_stage_next;

    logic        w_tmr_load;
    logic [31:0] w_tmr_value;
    logic        w_tmr_expired;

    logic       w_up_done;
    logic       w_down_done;
    logic       w_fault;
    logic [3:0] w_fault_stage;

    logic       r_up_done;
    logic       r_down_done;
    logic       r_fault;
    logic [3:0] r_fault_stage;
    rail_vec_t  r_rails;

    logic w_pg_awaited;
    logic w_all_pg;
    logic [3:0] w_stage_inc;

    assign w_all_pg    = ATX_PWR_OK & MGT_AVCC_PG & MGT_AVTTX_PG & MGT_AVCCPLL_PG;
    assign w_stage_inc = r_stage + 4'd1;

    // Power-good that gates the current stage.
    always_comb begin
        w_pg_awaited = 1'b0;
        case (r_stage)
            c_stage_atx:         w_pg_awaited = ATX_PWR_OK;
            c_stage_mgt_avcc:    w_pg_awaited = MGT_AVCC_PG;
            c_stage_mgt_avttx:   w_pg_awaited = MGT_AVTTX_PG;
            c_stage_mgt_avccpll: w_pg_awaited = MGT_AVCCPLL_PG;
            default:             w_pg_awaited = 1'b0;
        endcase
    end

    power_seq_timer u_timer (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .o_expired    (w_tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_stage <= c_stage_off;
        end else begin
            r_state <= w_state_next;
            r_stage <= w_stage_next;
        end
    end

    // Next-state logic. A power_down request takes priority over every
    // other event in the up/on states, including a simultaneous power-good
    // loss, so a requested shutdown is never reported as a fault.
    always_comb begin
        w_state_next  = r_state;
        w_stage_next  = r_stage;
        w_tmr_load    = 1'b0;
        w_tmr_value   = STEP_WAIT;
        w_up_done     = 1'b0;
        w_down_done   = 1'b0;
        w_fault       = 1'b0;
        w_fault_stage = r_fault_stage;

        case (r_state)
            ST_OFF: begin
                if (power_up && !power_down) begin
                    w_stage_next = c_stage_atx;
                    w_state_next = ST_UP_WAIT_PG;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = c_pg_wait_load;
                end
            end

            ST_UP_WAIT_PG: begin
                if (power_down) begin
                    w_state_next = ST_DOWN_STEP;
                    w_tmr_load   = 1'b1;
                end else if (w_pg_awaited) begin
                    w_state_next = ST_UP_STEP;
                    w_tmr_load   = 1'b1;
                end else if (w_tmr_expired) begin
                    w_fault       = 1'b1;
                    w_fault_stage = r_stage;
                    w_state_next  = ST_DOWN_STEP;
                    w_tmr_load    = 1'b1;
                end
            end

            ST_UP_STEP: begin
                if (power_down) begin
                    w_state_next = ST_DOWN_STEP;
                    w_tmr_load   = 1'b1;
                end else if (w_tmr_expired) begin
                    if (r_stage == c_stage_last) begin
                        w_state_next = ST_ON;
                        w_up_done    = 1'b1;
                    end else begin
                        w_stage_next = w_stage_inc;
                        w_tmr_load   = 1'b1;
                        if (stage_needs_pg(w_stage_inc)) begin
                            w_state_next = ST_UP_WAIT_PG;
                            w_tmr_value  = c_pg_wait_load;
                        end
                    end
                end
            end

            ST_ON: begin
                if (power_down) begin
                    w_state_next = ST_DOWN_STEP;
                    w_tmr_load   = 1'b1;
                end else if (!w_all_pg) begin
                    w_fault       = 1'b1;
                    w_fault_stage = c_fault_stage_pg_loss;
                    w_state_next  = ST_DOWN_STEP;
                    w_tmr_load    = 1'b1;
                end
            end

            ST_DOWN_STEP: begin
                if (r_stage == c_stage_off) begin
                    // Defensive: nothing left to switch off.
                    w_state_next = ST_OFF;
                    w_down_done  = 1'b1;
                end else if (w_tmr_expired) begin
                    w_stage_next = r_stage - 4'd1;
                    w_tmr_load   = 1'b1;
                    if (r_stage == c_stage_atx) begin
                        w_state_next = ST_OFF;
                        w_down_done  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_OFF;
                w_stage_next = c_stage_off;
            end
        endcase
    end

    // Rails decode the next stage so they switch on the same edge as the
    // stage register while still coming straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_up_done     <= 1'b0;
            r_down_done   <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= 4'd0;
            r_rails       <= rails_for_stage(c_stage_off);
        end else begin
            r_up_done     <= w_up_done;
            r_down_done   <= w_down_done;
            r_fault       <= w_fault;
            r_fault_stage <= w_fault_stage;
            r_rails       <= rails_for_stage(w_stage_next);
        end
    end

    assign power_up_done   = r_up_done;
    assign power_down_done = r_down_done;
    assign power_fault     = r_fault;
    assign fault_stage     = r_fault_stage;

    assign ATX_PS_ON_N    = r_rails.atx_ps_on_n;
    assign G12V_EN        = r_rails.main_en;
    assign G5V_EN         = r_rails.main_en;
    assign G3V3_EN        = r_rails.main_en;
    assign INHIBIT_2V5    = r_rails.inhibit_2v5;
    assign TRACK_2V5      = r_rails.track_2v5;
    assign INHIBIT_1V8    = r_rails.inhibit_1v8;
    assign INHIBIT_1V5    = r_rails.inhibit_1v5_1v2;
    assign INHIBIT_1V2    = r_rails.inhibit_1v5_1v2;
    assign INHIBIT_1V0    = r_rails.inhibit_1v0;
    assign MGT_AVCC_EN    = r_rails.mgt_avcc_en;
    assign MGT_AVTTX_EN   = r_rails.mgt_avttx_en;
    assign MGT_AVCCPLL_EN = r_rails.mgt_avccpll_en;

endmodule : power_sequencer
`default_nettype wire

// File: tb/tb_power_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_power_sequencer
//  Purpose  : Self-checking bench for power_sequencer (STEP_WAIT=4,
//             PG_TIMEOUT=16). A deadline-based reference model predicts the
//             stage, strobes and fault code every cycle; a simple board
//             model raises each power-good a programmable delay after its
//             rail is enabled. Directed scenarios are followed by random
//             requests, power-good glitches and resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_power_sequencer;

    localparam int SW  = 4;
    localparam int PGT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       power_up = 1'b0;
    logic       power_down = 1'b0;
    logic [3:0] pg_bus = 4'd0;   // {AVCCPLL, AVTTX, AVCC, ATX}

    logic       power_up_done, power_down_done, power_fault;
    logic [3:0] fault_stage;
    logic       ATX_PS_ON_N, TRACK_2V5, INHIBIT_2V5, INHIBIT_1V8, INHIBIT_1V5;
    logic       INHIBIT_1V2, INHIBIT_1V0, MGT_AVCC_EN, MGT_AVTTX_EN, MGT_AVCCPLL_EN;
    logic       G12V_EN, G5V_EN, G3V3_EN;

    power_sequencer #(.STEP_WAIT(32'd4), .PG_TIMEOUT(32'd16)) dut (
        .clk(clk), .reset(reset), .power_up(power_up), .power_down(power_down),
        .ATX_PWR_OK(pg_bus[0]), .MGT_AVCC_PG(pg_bus[1]),
        .MGT_AVTTX_PG(pg_bus[2]), .MGT_AVCCPLL_PG(pg_bus[3]),
        .power_up_done(power_up_done), .power_down_done(power_down_done),
        .power_fault(power_fault), .fault_stage(fault_stage),
        .ATX_PS_ON_N(ATX_PS_ON_N), .TRACK_2V5(TRACK_2V5), .INHIBIT_2V5(INHIBIT_2V5),
        .INHIBIT_1V8(INHIBIT_1V8), .INHIBIT_1V5(INHIBIT_1V5), .INHIBIT_1V2(INHIBIT_1V2),
        .INHIBIT_1V0(INHIBIT_1V0), .MGT_AVCC_EN(MGT_AVCC_EN), .MGT_AVTTX_EN(MGT_AVTTX_EN),
        .MGT_AVCCPLL_EN(MGT_AVCCPLL_EN), .G12V_EN(G12V_EN), .G5V_EN(G5V_EN), .G3V3_EN(G3V3_EN)
    );

    always #5 clk = ~clk;

    logic [12:0] obs_rails;
    assign obs_rails = {ATX_PS_ON_N, G12V_EN, G5V_EN, G3V3_EN, INHIBIT_2V5, TRACK_2V5,
                        INHIBIT_1V8, INHIBIT_1V5, INHIBIT_1V2, INHIBIT_1V0,
                        MGT_AVCC_EN, MGT_AVTTX_EN, MGT_AVCCPLL_EN};

    // Stage map of the sequence, in the same bit order as obs_rails.
    function automatic logic [12:0] rails_for(input int s);
        return {s < 1, s >= 2, s >= 2, s >= 2, s < 3, s >= 3,
                s < 4, s < 5, s < 5, s < 6, s >= 7, s >= 8, s >= 9};
    endfunction

    // Index into pg_bus of the power-good gating stage s, or -1.
    function automatic int pg_index(input int s);
        case (s)
            1:       return 0;
            7:       return 1;
            8:       return 2;
            9:       return 3;
            default: return -1;
        endcase
    endfunction

    typedef enum {M_IDLE, M_PG, M_SETTLE, M_RUN, M_FALL} mmode_t;

    mmode_t     m_mode;
    int         m_stage;
    int         m_mark;     // cycle at which the awaited rail was enabled
    int         m_due;      // cycle at which the next stage change is due
    bit         m_up, m_dn, m_flt;
    logic [3:0] m_fstage;

    int cyc = 0;
    int err_cnt = 0;
    int chk_cnt = 0;

    int age[4];
    int pg_delay[4];
    bit pg_stuck[4];
    int en_stage[4] = '{1, 7, 8, 9};

    int cnt_up, cnt_dn, cnt_flt;
    int t_avttx, t_fault, t_pll_fall, t_atx_off, t_req;
    bit prev_avttx, prev_pll, prev_atxn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic go_down(input int e);
        m_mode = M_FALL;
        m_due  = e + SW + 1;
    endtask

    task automatic take_fault(input int e, input logic [3:0] code);
        m_flt    = 1'b1;
        m_fstage = code;
        go_down(e);
    endtask

    // Reference model: advances one clock edge using the inputs the bench
    // is driving at that edge.
    task automatic model_step();
        int e;
        e = cyc;
        m_up = 1'b0; m_dn = 1'b0; m_flt = 1'b0;
        case (m_mode)
            M_IDLE: if (power_up && !power_down) begin
                m_stage = 1; m_mode = M_PG; m_mark = e;
            end
            M_PG: begin
                if (power_down) go_down(e);
                else if (pg_bus[pg_index(m_stage)]) begin
                    m_mode = M_SETTLE; m_due = e + SW + 1;
                end else if (e - m_mark >= PGT) take_fault(e, m_stage[3:0]);
            end
            M_SETTLE: begin
                if (power_down) go_down(e);
                else if (e >= m_due) begin
                    if (m_stage == 9) begin
                        m_mode = M_RUN; m_up = 1'b1;
                    end else begin
                        m_stage++;
                        if (pg_index(m_stage) >= 0) begin
                            m_mode = M_PG; m_mark = e;
                        end else m_due = e + SW + 1;
                    end
                end
            end
            M_RUN: begin
                if (power_down) go_down(e);
                else if (pg_bus != 4'hF) take_fault(e, 4'hF);
            end
            M_FALL: if (e >= m_due) begin
                m_stage--;
                m_due = e + SW + 1;
                if (m_stage == 0) begin
                    m_mode = M_IDLE; m_dn = 1'b1;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic drive_pg();
        for (int i = 0; i < 4; i++)
            pg_bus[i] = (m_stage >= en_stage[i]) && (age[i] > pg_delay[i]) && !pg_stuck[i];
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        for (int i = 0; i < 4; i++)
            age[i] = (m_stage >= en_stage[i]) ? age[i] + 1 : 0;
        @(negedge clk);
        check("rails", 32'(obs_rails), 32'(rails_for(m_stage)));
        check("strobes", 32'({power_up_done, power_down_done, power_fault}),
              32'({m_up, m_dn, m_flt}));
        check("fault_stage", 32'(fault_stage), 32'(m_fstage));
        if (power_up_done)   cnt_up++;
        if (power_down_done) cnt_dn++;
        if (power_fault) begin cnt_flt++; t_fault = cyc; end
        if (MGT_AVTTX_EN && !prev_avttx)  t_avttx = cyc;
        if (!MGT_AVCCPLL_EN && prev_pll)  t_pll_fall = cyc;
        if (ATX_PS_ON_N && !prev_atxn)    t_atx_off = cyc;
        prev_avttx = MGT_AVTTX_EN;
        prev_pll   = MGT_AVCCPLL_EN;
        prev_atxn  = ATX_PS_ON_N;
        drive_pg();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_up();
        power_up = 1'b1; tick(); power_up = 1'b0;
    endtask

    task automatic pulse_down();
        power_down = 1'b1; tick(); power_down = 1'b0; t_req = cyc;
    endtask

    task automatic wait_stage(input int k, input int limit);
        for (int i = 0; i < limit && m_stage != k; i++) tick();
        check("reach_stage", 32'(obs_rails), 32'(rails_for(k)));
    endtask

    task automatic reset_counts();
        cnt_up = 0; cnt_dn = 0; cnt_flt = 0;
        t_avttx = 0; t_fault = 0; t_pll_fall = 0; t_atx_off = 0;
    endtask

    task automatic set_plant(input int d);
        for (int i = 0; i < 4; i++) begin
            pg_delay[i] = d; pg_stuck[i] = 1'b0;
        end
    endtask

    task automatic rand_plant();
        for (int i = 0; i < 4; i++) begin
            pg_delay[i] = ($urandom_range(0, 6) == 0) ? int'($urandom_range(12, 24))
                                                      : int'($urandom_range(0, 4));
            pg_stuck[i] = ($urandom_range(0, 24) == 0);
        end
    endtask

    // Called at a falling edge; reset takes effect immediately.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_rails", 32'(obs_rails), 32'(rails_for(0)));
        check("reset_strobes", 32'({power_up_done, power_down_done, power_fault}), 32'd0);
        check("reset_fault_stage", 32'(fault_stage), 32'd0);
        m_mode = M_IDLE; m_stage = 0; m_fstage = 4'd0;
        m_up = 1'b0; m_dn = 1'b0; m_flt = 1'b0;
        for (int i = 0; i < 4; i++) age[i] = 0;
        pg_bus = 4'd0;
        prev_avttx = 1'b0; prev_pll = 1'b0; prev_atxn = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        set_plant(2);
        reset_counts();
        @(negedge clk);
        do_reset();
        run(3);

        // Full power-up with every power-good 2 cycles after its enable.
        reset_counts();
        pulse_up();
        run(119);
        check("up_done_once", 32'(cnt_up), 32'd1);
        check("up_no_fault", 32'(cnt_flt), 32'd0);
        check("up_all_on", 32'(MGT_AVCCPLL_EN), 32'd1);

        // Orderly power-down, one stage every STEP_WAIT+1 cycles.
        reset_counts();
        pulse_down();
        run(59);
        check("down_done_once", 32'(cnt_dn), 32'd1);
        check("down_first_step", 32'(t_pll_fall - t_req), 32'd5);
        check("down_span", 32'(t_atx_off - t_pll_fall), 32'd40);
        check("down_atx_off", 32'(ATX_PS_ON_N), 32'd1);

        // MGT_AVTTX power-good never arrives.
        set_plant(2);
        pg_stuck[2] = 1'b1;
        reset_counts();
        pulse_up();
        run(199);
        check("pgto_fault_once", 32'(cnt_flt), 32'd1);
        check("pgto_latency", 32'(t_fault - t_avttx), 32'd16);
        check("pgto_stage", 32'(fault_stage), 32'd8);
        check("pgto_down_done", 32'(cnt_dn), 32'd1);
        check("pgto_no_up_done", 32'(cnt_up), 32'd0);

        // One-cycle ATX_PWR_OK dropout while fully on.
        set_plant(2);
        reset_counts();
        pulse_up();
        run(119);
        pg_bus[0] = 1'b0;
        tick();
        run(59);
        check("loss_fault", 32'(cnt_flt), 32'd1);
        check("loss_stage", 32'(fault_stage), 32'hF);
        check("loss_down_done", 32'(cnt_dn), 32'd1);
        check("loss_atx_off", 32'(ATX_PS_ON_N), 32'd1);

        // Simultaneous requests in OFF, then an abort at stage 4.
        reset_counts();
        power_up = 1'b1; power_down = 1'b1;
        tick();
        power_up = 1'b0; power_down = 1'b0;
        run(10);
        check("both_no_change", 32'(obs_rails), 32'(rails_for(0)));
        check("both_no_strobe", 32'(cnt_up + cnt_dn + cnt_flt), 32'd0);
        pulse_up();
        wait_stage(4, 100);
        pulse_down();
        run(40);
        check("abort_no_fault", 32'(cnt_flt), 32'd0);
        check("abort_down_done", 32'(cnt_dn), 32'd1);
        check("abort_all_off", 32'(obs_rails), 32'(rails_for(0)));

        // Reset in the middle of the sequence.
        set_plant(2);
        pulse_up();
        wait_stage(6, 100);
        do_reset();
        reset_counts();
        run(30);
        check("post_reset_quiet", 32'(cnt_up + cnt_dn + cnt_flt), 32'd0);
        check("post_reset_off", 32'(obs_rails), 32'(rails_for(0)));

        // Random requests, power-good delays, glitches and resets.
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 2499) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 14) == 0) begin
                    rand_plant();
                    power_up = 1'b1;
                end
                if ($urandom_range(0, 149) == 0) power_down = 1'b1;
                if ($urandom_range(0, 149) == 0) pg_bus[$urandom_range(0, 3)] = 1'b0;
                tick();
                power_up = 1'b0;
                power_down = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_power_sequencer
`default_nettype wire

// File: doc/power_sequencer.md
POWER_SEQUENCER -- requirements
Module: power_sequencer

Interface
REQ-001 Param STEP_WAIT, default 32'h0001_ffff, settle cycles per stage after enable/disable.
REQ-002 Param PG_TIMEOUT, default 32'h003f_ffff, max cycles waiting for a power-good before fault.
REQ-003 clk  in  1  single clock (wb_clk_i of power_manager).
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 power_up  in  1  one-cycle request to sequence rails on.
REQ-006 power_down  in  1  one-cycle request to sequence rails off.
REQ-007 ATX_PWR_OK, MGT_AVCC_PG, MGT_AVTTX_PG, MGT_AVCCPLL_PG  in  1 each  power-good feedback, active-high.
REQ-008 power_up_done, power_down_done  out  1 each  one-cycle completion strobes.
REQ-009 power_fault  out  1  one-cycle strobe on power-good timeout or loss.
REQ-010 fault_stage  out  4  stage index of last fault; holds until next fault.
REQ-011 ATX_PS_ON_N  out  1  ATX supply on, active-low.
REQ-012 TRACK_2V5, INHIBIT_2V5, INHIBIT_1V8, INHIBIT_1V5, INHIBIT_1V2, INHIBIT_1V0  out  1 each  regulator track/inhibit (inhibit active-high).
REQ-013 MGT_AVCC_EN, MGT_AVTTX_EN, MGT_AVCCPLL_EN, G12V_EN, G5V_EN, G3V3_EN  out  1 each  enables, active-high.

Function
REQ-014 Stage register 0..9 (4 bits); every rail output SHALL be a registered decode "stage >= k", so rails switch strictly in order.
REQ-015 Stage map: 1 ATX_PS_ON_N=0; 2 G12V/G5V/G3V3_EN=1; 3 INHIBIT_2V5=0, TRACK_2V5=1; 4 INHIBIT_1V8=0; 5 INHIBIT_1V5=0, INHIBIT_1V2=0; 6 INHIBIT_1V0=0; 7 MGT_AVCC_EN=1; 8 MGT_AVTTX_EN=1; 9 MGT_AVCCPLL_EN=1.
REQ-016 FSM states: OFF, UP_STEP, UP_WAIT_PG, ON, DOWN_STEP.
REQ-017 OFF + power_up: stage<=1, enter UP_WAIT_PG (stage 1 gated by ATX_PWR_OK).
REQ-018 Stages 1,7,8,9 advance when respective PG high, then after STEP_WAIT further cycles; stages 2-6 advance after STEP_WAIT cycles.
REQ-019 After stage 9 completes: enter ON, pulse power_up_done one cycle.
REQ-020 Any awaited PG not high within PG_TIMEOUT cycles: pulse power_fault, latch fault_stage=current stage, enter DOWN_STEP.
REQ-021 In ON, deassertion of ATX_PWR_OK or any MGT PG for 1 cycle: power_fault, fault_stage=4'hF, enter DOWN_STEP.
REQ-022 DOWN_STEP: decrement stage every STEP_WAIT cycles, no PG checks; on reaching 0 enter OFF, pulse power_down_done.
REQ-023 power_down in UP_STEP/UP_WAIT_PG/ON: abort, enter DOWN_STEP from current stage (no fault).
REQ-024 power_up and power_down same cycle: power_down wins.
REQ-025 power_up outside OFF, power_down in OFF or DOWN_STEP: ignored (no strobe).
REQ-026 Timer 32-bit down-counter, reloaded on every stage change; STEP_WAIT=0 means advance next cycle.

Reset
REQ-027 Asserted reset: stage=0, state OFF, ATX_PS_ON_N=1, all INHIBIT=1, TRACK_2V5=0, all EN=0, strobes=0, fault_stage=0, timers=0.
REQ-028 Reset mid-sequence SHALL drop all rails immediately (no reverse sequencing); no done strobe on release.

Structure
REQ-029 Shared package power_seq_pkg: state encodings, stage index constants, fault_stage code 4'hF.
REQ-030 One sub-module power_seq_timer (load value, load strobe, expired flag); instantiated once, shared by settle and PG-timeout counting.

Verification (STEP_WAIT=4, PG_TIMEOUT=16)
REQ-031 power_up, all PGs high 2 cycles after each enable -> outputs change in REQ-015 order, power_up_done exactly once, state ON.
REQ-032 From ON, power_down -> outputs revert stage 9..1 in reverse, 5 cycles apart, ATX_PS_ON_N=1 last, power_down_done once.
REQ-033 MGT_AVTTX_PG held low -> power_fault 16 cycles after MGT_AVTTX_EN=1, fault_stage=8, reverse down to 0, power_down_done.
REQ-034 In ON, drop ATX_PWR_OK 1 cycle -> power_fault, fault_stage=4'hF, full power-down.
REQ-035 power_up and power_down same cycle in OFF -> no change; power_down at stage 4 -> descends from 4, no fault.
REQ-036 reset at stage 6 -> next clk all outputs at reset values, no strobes after release.
